// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, digit limits and clamp helper.
package bcd_pkg;
    typedef logic [3:0] bcd_digit_t;
    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit register with load, up/down step and combinational carry/borrow out.
// cout reports "this digit and all below are at the terminal value", independent of en.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  bcd_digit_t init,
    input  logic       load,
    input  bcd_digit_t load_val,
    input  logic       en,
    input  logic       up,
    input  logic       cin,
    output bcd_digit_t digit,
    output logic       cout
);
    bcd_digit_t nxt;
    always_comb begin
        nxt = digit;
        if (load)
            nxt = bcd_clamp(load_val);
        else if (en && cin)
            nxt = up ? ((digit == BCD_MAX) ? BCD_MIN : digit + 4'd1)
                     : ((digit == BCD_MIN) ? BCD_MAX : digit - 4'd1);
    end
    assign cout = cin && (up ? (digit == BCD_MAX) : (digit == BCD_MIN));
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) digit <= bcd_clamp(init);
        else          digit <= nxt;
endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: cascaded BCD up/down counter with load and terminal-count pulse.
// Define BCD_COUNTER_SAT_EN to saturate at all-9s/all-0s instead of wrapping.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int                  DIGITS = 4,
    parameter logic [4*DIGITS-1:0] INIT   = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tc
);
    logic [DIGITS:0] chain;
    logic            step;
    logic            term;
    logic            adv;
    assign chain[0] = 1'b1;
    assign step     = en && !load;
    assign term     = chain[DIGITS];
`ifdef BCD_COUNTER_SAT_EN
    assign adv = step && !term;
`else
    assign adv = step;
`endif
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .reset_n  (reset_n),
            .init     (INIT[4*i +: 4]),
            .load     (load),
            .load_val (load_val[4*i +: 4]),
            .en       (adv),
            .up       (up),
            .cin      (chain[i]),
            .digit    (count[4*i +: 4]),
            .cout     (chain[i+1])
        );
    end
    // A step attempted from the terminal value is the wrap (or saturation) event.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) tc <= 1'b0;
        else          tc <= step && term;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: directed self-checking bench, DIGITS=2, INIT=8'h42.
module tb_bcd_updown_counter;
    logic       clk = 0;
    logic       reset_n = 1;
    logic       en = 0;
    logic       up = 1;
    logic       load = 0;
    logic [7:0] load_val = '0;
    logic [7:0] count;
    logic       tc;
    int         passed = 0;
    int         total = 0;

    bcd_updown_counter #(.DIGITS(2), .INIT(8'h42)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .tc(tc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1; load_val = v; en = 0;
        tick();
        load = 0;
    endtask

    task automatic test_reset();
        #2 reset_n = 0;
        #1;
        total++; if (count !== 8'h42) $display("FAIL reset_init count=%h exp=42", count); else passed++;
        total++; if (tc !== 1'b0) $display("FAIL reset_init tc=%b exp=0", tc); else passed++;
        tick();
        reset_n = 1;
        en = 1; up = 1;
        tick();
        total++; if (count !== 8'h43) $display("FAIL first_step count=%h exp=43", count); else passed++;
        tick();
        #2 reset_n = 0;
        #1;
        total++; if (count !== 8'h42) $display("FAIL async_reset count=%h exp=42", count); else passed++;
        total++; if (tc !== 1'b0) $display("FAIL async_reset tc=%b exp=0", tc); else passed++;
        load = 1; load_val = 8'h77;
        tick();
        total++; if (count !== 8'h42) $display("FAIL reset_hold count=%h exp=42", count); else passed++;
        load = 0; en = 0;
        reset_n = 1;
    endtask

    task automatic test_load_clamp();
        load = 1; en = 1; up = 1; load_val = 8'hAF;
        tick();
        total++; if (count !== 8'h99) $display("FAIL load_clamp_af count=%h exp=99", count); else passed++;
        total++; if (tc !== 1'b0) $display("FAIL load_clamp_af tc=%b exp=0", tc); else passed++;
        load_val = 8'h3C;
        tick();
        total++; if (count !== 8'h39) $display("FAIL load_clamp_3c count=%h exp=39", count); else passed++;
        load = 0; en = 0;
    endtask

    task automatic test_inc_wrap();
        do_load(8'h98);
        en = 1; up = 1;
        tick();
        total++; if (count !== 8'h99) $display("FAIL inc_98 count=%h exp=99", count); else passed++;
        total++; if (tc !== 1'b0) $display("FAIL inc_98 tc=%b exp=0", tc); else passed++;
        tick();
`ifdef BCD_COUNTER_SAT_EN
        total++; if (count !== 8'h99) $display("FAIL inc_sat count=%h exp=99", count); else passed++;
`else
        total++; if (count !== 8'h00) $display("FAIL inc_wrap count=%h exp=00", count); else passed++;
`endif
        total++; if (tc !== 1'b1) $display("FAIL inc_wrap tc=%b exp=1", tc); else passed++;
        en = 0;
        tick();
        total++; if (tc !== 1'b0) $display("FAIL inc_wrap_pulse tc=%b exp=0", tc); else passed++;
        do_load(8'h19);
        en = 1;
        tick();
        total++; if (count !== 8'h20) $display("FAIL inc_carry count=%h exp=20", count); else passed++;
        en = 0;
    endtask

    task automatic test_dec_borrow();
        do_load(8'h10);
        en = 1; up = 0;
        tick();
        total++; if (count !== 8'h09) $display("FAIL dec_10 count=%h exp=09", count); else passed++;
        total++; if (tc !== 1'b0) $display("FAIL dec_10 tc=%b exp=0", tc); else passed++;
        tick();
        total++; if (count !== 8'h08) $display("FAIL dec_09 count=%h exp=08", count); else passed++;
        total++; if (tc !== 1'b0) $display("FAIL dec_09 tc=%b exp=0", tc); else passed++;
        en = 0;
    endtask

    task automatic test_dec_terminal();
        logic [7:0] exp_c [3];
        logic       exp_t [3];
`ifdef BCD_COUNTER_SAT_EN
        exp_c = '{8'h00, 8'h00, 8'h00};
        exp_t = '{1'b1, 1'b1, 1'b1};
`else
        exp_c = '{8'h99, 8'h98, 8'h97};
        exp_t = '{1'b1, 1'b0, 1'b0};
`endif
        do_load(8'h00);
        en = 1; up = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (count !== exp_c[i]) $display("FAIL dec_term[%0d] count=%h exp=%h", i, count, exp_c[i]); else passed++;
            total++; if (tc !== exp_t[i]) $display("FAIL dec_term[%0d] tc=%b exp=%b", i, tc, exp_t[i]); else passed++;
        end
        en = 0;
    endtask

    task automatic test_hold();
        do_load(8'h57);
        en = 0;
        for (int i = 0; i < 10; i++) begin
            up = ~up;
            tick();
            total++; if (count !== 8'h57 || tc !== 1'b0) $display("FAIL hold[%0d] count=%h tc=%b exp=57/0", i, count, tc); else passed++;
        end
    endtask

    task automatic test_load_terminal();
        do_load(8'h99);
        load = 1; en = 1; up = 1; load_val = 8'h99;
        tick();
        total++; if (count !== 8'h99) $display("FAIL load_term count=%h exp=99", count); else passed++;
        total++; if (tc !== 1'b0) $display("FAIL load_term tc=%b exp=0", tc); else passed++;
        load = 0; en = 0;
    endtask

    initial begin
        test_reset();
        test_load_clamp();
        test_inc_wrap();
        test_dec_borrow();
        test_dec_terminal();
        test_hold();
        test_load_terminal();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of cascaded BCD digits (legal range 1..8).
REQ-002 SHALL have parameter INIT, default 0, binary-coded decimal reset value, 4*DIGITS bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  count enable; one step per clock while high.
REQ-006 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-008 SHALL have port load_val  input  4*DIGITS  BCD value to load; digit i at bits [4i+3:4i].
REQ-009 SHALL have port count  output  4*DIGITS  current BCD value, registered.
REQ-010 SHALL have port tc  output  1  registered terminal-count pulse.

Function
REQ-011 SHALL give load priority over en: load=1 sets count to load_val at the next edge, regardless of en/up.
REQ-012 SHALL clamp, on load, any load_val digit above 9 to 9, per digit independently.
REQ-013 SHALL, with en=1, up=1, load=0, increment digit 0; a digit at 9 goes to 0 and carries into the next digit in the same cycle.
REQ-014 SHALL, with en=1, up=0, load=0, decrement digit 0; a digit at 0 goes to 9 and borrows from the next digit in the same cycle.
REQ-015 SHALL update all digits on the same clock edge: fully synchronous ripple-free carry/borrow, with no derived clocks.
REQ-016 SHALL wrap all-9s to all-0s on increment and all-0s to all-9s on decrement (wrap mode).
REQ-017 SHALL assert tc for exactly one cycle, coincident with the count value produced by a wrap or saturation event.
REQ-018 SHALL hold count and deassert tc when en=0 and load=0.
REQ-019 SHALL keep tc low on a load cycle, even if load_val equals a terminal value.
REQ-020 SHALL keep every count digit within 0..9 at all times.
REQ-021 SHALL give one step per enabled cycle, with count visible one clock after the enabling edge (latency 1).

Reset
REQ-022 SHALL set count to INIT, with digits clamped per REQ-012, and tc to 0 immediately when reset_n falls, independent of clk.
REQ-023 SHALL hold reset values while reset_n=0, ignoring load/en.
REQ-024 SHALL resume counting on the first rising clk edge after reset_n rises.
REQ-025 SHALL abandon any mid-operation step on reset; no partial carry is retained.

Configuration
REQ-026 SHALL support macro BCD_COUNTER_SAT_EN.
- Defined: increment at all-9s holds all-9s and decrement at all-0s holds all-0s; tc pulses on the attempted step.
- Undefined: wrap behaviour per REQ-016.
REQ-027 SHALL keep the port list identical with and without the macro.

Structure
REQ-028 SHALL place in shared package bcd_pkg:
- typedef bcd_digit_t (4 bits)
- constants BCD_MAX=9 and BCD_MIN=0
- clamp function for digit values above 9
REQ-029 SHALL implement one sub-module bcd_digit, instantiated DIGITS times via generate. Ports:
- carry/borrow in
- direction
- load value
- digit out
- carry/borrow out (combinational)
REQ-030 SHALL contain no latches, with all state in the top-level or digit registers under the single clk/reset_n.

Verification
REQ-031 SHALL cover reset: DIGITS=2, INIT=8'h42, reset_n pulsed low mid-count -> count=8'h42, tc=0 immediately, without a clock edge.
REQ-032 SHALL cover increment wrap: load 8'h98, en=1, up=1 for 2 cycles -> 8'h99, then 8'h00 with tc=1 for one cycle (macro undefined).
REQ-033 SHALL cover decrement borrow: load 8'h10, en=1, up=0 -> 8'h09, next 8'h08, tc=0 throughout.
REQ-034 SHALL cover load clamp and priority: load=1, en=1, load_val=8'hAF -> count=8'h99, tc=0.
REQ-035 SHALL cover saturation (BCD_COUNTER_SAT_EN): at 8'h00, en=1, up=0 for 3 cycles -> count stays 8'h00, tc high each cycle.
REQ-036 SHALL cover hold: en=0 for 10 cycles at 8'h57 -> count=8'h57, tc=0; a direction toggle with en=0 has no effect.
